adc_buffer_streamer: RTL and testbench
======================================

Name: adc_buffer_streamer

Overview:
- Downstream consumer of the ADC capture stage.
- Once a capture completes, it reads the 4096-sample capture buffer through the capture stage's synchronous read port.
- It emits the samples in address order on a valid/ready byte stream, then two 16-bit checksum beats. The stream feeds the UART/host link.
- Sustains 1 beat/cycle under continuous ready and tolerates arbitrary backpressure without loss.

Parameters:
- DATA_WIDTH, 8, sample width in bits (≥8)
- ADDR_WIDTH, 12, buffer address width
- DEPTH, 4096, samples per readout (≤ 2^ADDR_WIDTH)
- CHECKSUM_EN, 1, 1 = append 2 checksum beats after the samples; 0 = no trailer

Ports:
- adc_clock  in  1  single clock, shared with the capture stage
- reset  in  1  synchronous, active-high
- capture_done  in  1  capture stage buffer is full and valid
- start_readout  in  1  request one full readout pass
- read_addr  out  ADDR_WIDTH  address to the capture buffer read port
- read_data  in  DATA_WIDTH  buffer data; valid the cycle after read_addr is presented
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  sink ready
- m_last  out  1  marks the final beat of a pass
- busy  out  1  pass in progress
- readout_done  out  1  pass complete; held high until the next accepted start or reset
- checksum  out  16  checksum of the last completed pass

Behaviour:
- Reset (synchronous) clears state to IDLE and, on the next edge:
  - m_valid=0, m_last=0, busy=0, readout_done=0, checksum=0, read_addr=0
  - internal FIFO emptied, address counter and running sum cleared
- Reset asserted mid-pass aborts the pass with no further beats. Partial checksum is discarded.
- Beat transfer occurs when m_valid && m_ready.
- While m_valid=1 && m_ready=0, m_data and m_last hold stable. m_valid never drops without a transfer.
- States:
  - IDLE: start_readout && capture_done → FETCH. start_readout with capture_done=0 is ignored: no state change, no beats.
  - FETCH: issues read_addr 0..DEPTH-1, one per cycle, only while the 2-entry output FIFO has room for the in-flight read.
    - read_data is captured into the FIFO one cycle after its address.
    - After the last data beat transfers → CK_LO if CHECKSUM_EN, else DONE.
  - CK_LO: emits beat {zero-extend, sum[7:0]}.
  - CK_HI: emits beat {zero-extend, sum[15:8]} with m_last=1. Transfer → DONE.
  - DONE: readout_done=1, busy=0, checksum holds the final sum. Another start_readout (with capture_done=1) re-runs the pass from address 0 and clears readout_done on the accepting edge.
- With CHECKSUM_EN=0, m_last=1 on the sample at address DEPTH-1.
- busy=1 in FETCH, CK_LO and CK_HI.
- Latency and throughput:
  - start accepted at edge N → read_addr=0 presented after N → first m_valid=1 after edge N+2.
  - With m_ready held high: one beat per cycle, no bubbles.
  - Full pass = DEPTH + 2 beats.
- Checksum:
  - 16-bit modular sum of all DEPTH samples, each zero-extended; wraps mod 2^16.
  - Accumulated on data-beat transfer, not on read. Checksum beats are not summed.
- Boundaries:
  - Address counter stops at DEPTH-1 and never wraps to 0 within a pass.
  - No read is issued when the FIFO plus the in-flight read would exceed 2 entries.
  - A start_readout arriving during busy is ignored.
  - capture_done falling mid-pass does not abort the pass. Data integrity is then the caller's responsibility.
  - In the same cycle, the last-beat transfer and a new start_readout: start is ignored (state not yet DONE).

Test Plan:
- Fill buffer model with addr[7:0] (0,1,…,255,0,…), capture_done=1, pulse start, m_ready=1 → 4098 beats back-to-back; first m_valid 2 cycles after start; data matches addr[7:0]; checksum beats 0x00, 0xF8 (sum 16×32640 = 522240 mod 65536 = 0xF800); m_last only on beat 4098; readout_done=1, checksum=0xF800.
- Same data, m_ready random 30% duty → identical 4098-beat sequence. m_data/m_last never change while m_valid && !m_ready. No duplicates or drops.
- capture_done=0, pulse start → m_valid stays 0 and busy stays 0 for 100 cycles.
- All samples 0xFF → sum 4096×255 = 1044480 mod 65536 = 0xF000; trailer 0x00, 0xF0.
- Reset asserted at beat 1000 → next edge m_valid=0, busy=0, readout_done=0. New start → stream restarts at address 0 with the correct full checksum.
- CHECKSUM_EN=0 → exactly 4096 beats; m_last on address 4095; start during busy ignored; second start after DONE repeats the identical stream.

Source files
------------

// File: rtl/adc_buffer_streamer.sv
// Reads a full capture buffer through its synchronous read port and streams the
// samples, followed by an optional 16-bit checksum trailer, on a valid/ready link.
module adc_buffer_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 4096,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                  adc_clock,
    input  logic                  reset,
    input  logic                  capture_done,
    input  logic                  start_readout,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  readout_done,
    output logic [15:0]           checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, CK_LO, CK_HI, DONE} state_t;

    state_t                state, state_next;
    logic                  issue_done;
    logic                  pend;
    logic                  pend_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [15:0]           sum;

    logic                  start_ok;
    logic                  pop;
    logic                  issue;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [15:0]           sample16;

    assign head_data = fifo_data[rd_ptr];
    assign head_last = fifo_last[rd_ptr];
    assign sample16  = 16'(head_data);
    assign start_ok  = start_readout && capture_done && (state == IDLE || state == DONE);
    assign pop       = (state == FETCH) && (count != 2'd0) && m_ready;
    // A read is only issued if its data is guaranteed a FIFO slot when it lands,
    // counting the read already in flight and any pop happening this cycle.
    assign issue     = (state == FETCH) && !issue_done &&
                       (({1'b0, count} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = FETCH;
            end
            FETCH: begin
                m_valid = (count != 2'd0);
                m_data  = head_data;
                m_last  = head_last && !CHECKSUM_EN;
                if (pop && head_last) state_next = CHECKSUM_EN ? CK_LO : DONE;
            end
            CK_LO: begin
                m_valid     = 1'b1;
                m_data[7:0] = sum[7:0];
                if (m_ready) state_next = CK_HI;
            end
            CK_HI: begin
                m_valid     = 1'b1;
                m_data[7:0] = sum[15:8];
                m_last      = 1'b1;
                if (m_ready) state_next = DONE;
            end
            DONE: begin
                if (start_ok) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state == FETCH) || (state == CK_LO) || (state == CK_HI);
    assign readout_done = (state == DONE);

    always_ff @(posedge adc_clock) begin
        if (reset) begin
            state        <= IDLE;
            read_addr    <= '0;
            issue_done   <= 1'b0;
            pend         <= 1'b0;
            pend_last    <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            sum          <= '0;
            checksum     <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                read_addr  <= '0;
                issue_done <= 1'b0;
                pend       <= 1'b0;
                pend_last  <= 1'b0;
                sum        <= '0;
            end else begin
                pend      <= issue;
                pend_last <= issue && (read_addr == LAST_ADDR);
                if (issue) begin
                    if (read_addr == LAST_ADDR) issue_done <= 1'b1;
                    else                        read_addr  <= read_addr + 1'b1;
                end
                if (pend) begin
                    fifo_data[wr_ptr] <= read_data;
                    fifo_last[wr_ptr] <= pend_last;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    sum    <= sum + sample16;
                end
                if (pend && !pop)      count <= count + 2'd1;
                else if (!pend && pop) count <= count - 2'd1;
                if (CHECKSUM_EN && state == CK_HI && m_ready)
                    checksum <= sum;
                if (!CHECKSUM_EN && pop && head_last)
                    checksum <= sum + sample16;
            end
        end
    end

endmodule

// File: tb/tb_adc_buffer_streamer.sv
// Directed bench: two streamers (with and without checksum trailer) read a shared
// buffer model; every beat, hold condition and end-of-pass status is checked.
module tb_adc_buffer_streamer;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_done;
    logic        start_a, start_b;
    logic        m_ready;
    logic [11:0] addr_a, addr_b;
    logic [7:0]  rd_a, rd_b;
    logic [7:0]  md_a, md_b;
    logic        mv_a, mv_b, ml_a, ml_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] ck_a, ck_b;

    logic [7:0]  mem [DEPTH];
    logic        sel;
    logic        mv, ml, busy_s, done_s;
    logic [7:0]  md;
    logic [11:0] addr_s;
    logic [15:0] ck_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_buffer_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DEPTH(DEPTH), .CHECKSUM_EN(1'b1)) dut_ck (
        .adc_clock(clk), .reset(reset), .capture_done(capture_done), .start_readout(start_a),
        .read_addr(addr_a), .read_data(rd_a), .m_data(md_a), .m_valid(mv_a), .m_ready(m_ready),
        .m_last(ml_a), .busy(busy_a), .readout_done(done_a), .checksum(ck_a)
    );

    adc_buffer_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .DEPTH(DEPTH), .CHECKSUM_EN(1'b0)) dut_nock (
        .adc_clock(clk), .reset(reset), .capture_done(capture_done), .start_readout(start_b),
        .read_addr(addr_b), .read_data(rd_b), .m_data(md_b), .m_valid(mv_b), .m_ready(m_ready),
        .m_last(ml_b), .busy(busy_b), .readout_done(done_b), .checksum(ck_b)
    );

    always @(posedge clk) begin
        rd_a <= mem[addr_a];
        rd_b <= mem[addr_b];
    end

    always_comb begin
        mv     = sel ? mv_b   : mv_a;
        ml     = sel ? ml_b   : ml_a;
        md     = sel ? md_b   : md_a;
        busy_s = sel ? busy_b : busy_a;
        done_s = sel ? done_b : done_a;
        addr_s = sel ? addr_b : addr_a;
        ck_s   = sel ? ck_b   : ck_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    endtask

    // One readout pass on the selected DUT; abort_at>0 resets after that many beats.
    task automatic run_pass(input bit use_b, input int ready_pct, input int abort_at,
                            input bit poke, input logic [15:0] exp_sum);
        int         total;
        int         beats;
        int         cycles;
        bit         stalled;
        bit         poked;
        logic [7:0] held_d;
        logic       held_l;
        logic [7:0] exp_d;
        total   = use_b ? DEPTH : DEPTH + 2;
        beats   = 0;
        cycles  = 0;
        stalled = 1'b0;
        poked   = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        sel     = use_b;
        @(negedge clk);
        m_ready = 1'b0;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("addr0_after_start", 32'(addr_s), 32'd0);
        check("valid_low_n", 32'(mv), 32'd0);
        check("busy_after_start", 32'(busy_s), 32'd1);
        check("done_cleared", 32'(done_s), 32'd0);
        @(negedge clk);
        check("valid_low_n1", 32'(mv), 32'd0);
        while (beats < total && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            set_start(1'b0);
            if (cycles == 1) check("first_valid_n2", 32'(mv), 32'd1);
            if (stalled) begin
                check("hold_valid", 32'(mv), 32'd1);
                check("hold_data", 32'(md), 32'(held_d));
                check("hold_last", 32'(ml), 32'(held_l));
            end
            if (poke && !poked && beats == 100) begin
                set_start(1'b1);
                poked = 1'b1;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            if (mv && m_ready) begin
                if (beats < DEPTH)       exp_d = mem[beats];
                else if (beats == DEPTH) exp_d = exp_sum[7:0];
                else                     exp_d = exp_sum[15:8];
                check("beat_data", 32'(md), 32'(exp_d));
                check("beat_last", 32'(ml), 32'(beats == total - 1));
                beats++;
                stalled = 1'b0;
                if (abort_at > 0 && beats == abort_at) break;
            end else begin
                stalled = mv;
                held_d  = md;
                held_l  = ml;
            end
        end
        if (abort_at > 0) begin
            @(negedge clk);
            m_ready = 1'b0;
            reset   = 1'b1;
            @(negedge clk);
            reset   = 1'b0;
            check("abort_valid", 32'(mv), 32'd0);
            check("abort_busy", 32'(busy_s), 32'd0);
            check("abort_done", 32'(done_s), 32'd0);
            check("abort_addr", 32'(addr_s), 32'd0);
            check("abort_checksum", 32'(ck_s), 32'd0);
            return;
        end
        check("pass_complete", 32'(beats), 32'(total));
        if (ready_pct >= 100) check("no_bubbles", 32'(cycles), 32'(total));
        @(negedge clk);
        set_start(1'b0);
        m_ready = 1'b0;
        check("end_valid", 32'(mv), 32'd0);
        check("end_busy", 32'(busy_s), 32'd0);
        check("end_done", 32'(done_s), 32'd1);
        check("end_checksum", 32'(ck_s), 32'(exp_sum));
    endtask

    initial begin
        reset        = 1'b1;
        capture_done = 1'b1;
        start_a      = 1'b0;
        start_b      = 1'b0;
        m_ready      = 1'b0;
        sel          = 1'b0;
        fill_ramp();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(mv_a), 32'd0);
        check("rst_last", 32'(ml_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_checksum", 32'(ck_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_valid_b", 32'(mv_b), 32'd0);
        reset = 1'b0;

        // ramp data, continuous ready: sum 16*32640 mod 2^16 = 0xF800
        run_pass(1'b0, 100, 0, 1'b0, 16'hF800);
        // same data, ~30% ready duty
        run_pass(1'b0, 30, 0, 1'b0, 16'hF800);

        // start without a completed capture is ignored
        capture_done = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            check("nocap_valid", 32'(mv_a), 32'd0);
            check("nocap_busy", 32'(busy_a), 32'd0);
            @(negedge clk);
        end
        check("nocap_done_kept", 32'(done_a), 32'd1);
        capture_done = 1'b1;

        // all 0xFF: 4096*255 mod 2^16 = 0xF000
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        run_pass(1'b0, 100, 0, 1'b0, 16'hF000);

        // reset at beat 1000, then a clean full pass
        fill_ramp();
        run_pass(1'b0, 100, 1000, 1'b0, 16'hF800);
        run_pass(1'b0, 100, 0, 1'b0, 16'hF800);

        // no trailer: 4096 beats, last on addr 4095, start during busy ignored
        run_pass(1'b1, 100, 0, 1'b1, 16'hF800);
        run_pass(1'b1, 50, 0, 1'b0, 16'hF800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
